// File: rtl/fc_neuron_stream.sv
// Streaming fully-connected neuron: accumulates LANES weighted activations per beat, then emits one result.
// Optional ReLU on the result is enabled by defining FC_NEURON_RELU_EN; without it the raw signed sum is output.
module fc_neuron_stream #(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int LANES = 8,
  localparam int ACC_W = 2*WIDTH + $clog2(IN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_we,
  input  logic [$clog2(IN)-1:0]     w_addr,
  input  logic signed [WIDTH-1:0]   w_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*LANES-1:0]    in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   out_data
);

  localparam int AW    = $clog2(IN);
  localparam int BEATS = IN / LANES;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (IN % LANES != 0) begin : g_bad_cfg
    $error("fc_neuron_stream: IN must be a multiple of LANES");
  end

  typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;

  state_t                   state;
  logic [BC_W-1:0]          beat_cnt;
  logic                     drain_cnt;
  logic signed [WIDTH-1:0]  w_mem [IN];
  logic signed [ACC_W-1:0]  psum_p1;
  logic                     vld_p1;
  logic signed [ACC_W-1:0]  acc_p2;
  logic signed [ACC_W-1:0]  lane_sum;
  logic [AW-1:0]            lane_addr [LANES];
  logic signed [2*WIDTH-1:0] prod [LANES];
  logic                     accept;
  logic                     w_ok;

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
`ifdef FC_NEURON_RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign accept = in_valid && in_ready && (state == ACCUM);
  // Weights may only change between vectors, never underneath an accepted beat.
  assign w_ok   = w_we && (state == ACCUM) && (beat_cnt == '0) && !accept && (int'(w_addr) < IN);

  always_ff @(posedge clk) begin
    if (w_ok) w_mem[w_addr] <= w_data;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_addr[k] = AW'(int'(beat_cnt) * LANES + k);
    assign prod[k]      = $signed(in_data[k*WIDTH +: WIDTH]) * w_mem[lane_addr[k]];
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) lane_sum = lane_sum + ACC_W'(prod[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      beat_cnt  <= '0;
      drain_cnt <= 1'b0;
      psum_p1   <= '0;
      vld_p1    <= 1'b0;
      acc_p2    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // Stage 1: per-beat lane sum
      vld_p1 <= accept;
      if (accept) psum_p1 <= lane_sum;
      // Stage 2: running accumulation, active in every state
      if (vld_p1) acc_p2 <= acc_p2 + psum_p1;

      case (state)
        ACCUM: begin
          if (accept) begin
            if (beat_cnt == BC_W'(BEATS-1)) begin
              beat_cnt  <= '0;
              drain_cnt <= 1'b0;
              in_ready  <= 1'b0;
              state     <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        // First drain cycle lets the last psum land in acc; second captures the result.
        DRAIN: begin
          if (!drain_cnt) begin
            drain_cnt <= 1'b1;
          end else begin
            out_data  <= relu(acc_p2);
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_p2    <= '0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_neuron_stream.sv
// Bench for fc_neuron_stream: fixed-pattern table, randomized vectors against a dot-product model, write/reset corners.
module tb_fc_neuron_stream;
  localparam int WIDTH = 8;
  localparam int IN    = 128;
  localparam int LANES = 8;
  localparam int BEATS = IN / LANES;
  localparam int AW    = $clog2(IN);
  localparam int ACC_W = 2*WIDTH + $clog2(IN);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   w_we;
  logic [AW-1:0]          w_addr;
  logic [WIDTH-1:0]       w_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH*LANES-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       out_data;

  fc_neuron_stream #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wm [IN];
  int xv [IN];

  typedef struct {
    int     w;
    int     x;
    longint raw;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint apply_relu(input longint s);
`ifdef FC_NEURON_RELU_EN
    return (s < 0) ? 0 : s;
`else
    return s;
`endif
  endfunction

  // Reference: plain dot product of the weights and activations last presented.
  function automatic longint model();
    longint s = 0;
    for (int i = 0; i < IN; i++) s += longint'(wm[i]) * longint'(xv[i]);
    return apply_relu(s);
  endfunction

  function automatic longint dout();
    return longint'($signed(out_data));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all();
    for (int i = 0; i < IN; i++) begin
      w_we   = 1'b1;
      w_addr = AW'(i);
      w_data = WIDTH'(wm[i]);
      tick();
    end
    w_we = 1'b0;
  endtask

  task automatic drive_beat(input int b);
    for (int k = 0; k < LANES; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(xv[b*LANES+k]);
    in_valid = 1'b1;
  endtask

  // Sends beats first..last; optional random bubbles and an illegal weight write at wr_beat.
  task automatic send_beats(input int first, input int last, input bit gaps, input int wr_beat);
    for (int b = first; b <= last; b++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          in_valid = 1'b0;
          in_data  = {$urandom(), $urandom()};
          tick();
        end
      end
      drive_beat(b);
      if (b == wr_beat) begin
        w_we   = 1'b1;
        w_addr = AW'($urandom_range(0, IN-1));
        w_data = WIDTH'($urandom());
      end
      tick();
      w_we = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_vector(input string name, input longint exp, input int stall);
    longint hold;
    bit ok;
    check({name, "_lat0"}, out_valid, 0);
    tick();
    check({name, "_lat1"}, out_valid, 0);
    tick();
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, dout(), exp);
    hold = dout();
    ok = 1'b1;
    in_valid = 1'b1;
    in_data  = {$urandom(), $urandom()};
    for (int s = 0; s < stall; s++) begin
      tick();
      if (out_valid !== 1'b1 || dout() != hold || in_ready !== 1'b0) ok = 1'b0;
    end
    if (stall > 0) check({name, "_stall_stable"}, ok, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_drop_valid"}, out_valid, 0);
    check({name, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", dout(), 0);

    tbl[0] = '{w: 1,    x: 1,    raw: 128};
    tbl[1] = '{w: -1,   x: 1,    raw: -128};
    tbl[2] = '{w: 127,  x: -128, raw: -2080768};
    tbl[3] = '{w: 0,    x: 77,   raw: 0};
    tbl[4] = '{w: 2,    x: 3,    raw: 768};
    tbl[5] = '{w: -3,   x: -4,   raw: 1536};
    tbl[6] = '{w: -128, x: -128, raw: 2097152};

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < IN; i++) begin
        wm[i] = tbl[t].w;
        xv[i] = tbl[t].x;
      end
      load_all();
      send_beats(0, BEATS-1, 1'b0, -1);
      finish_vector($sformatf("tbl%0d", t), apply_relu(tbl[t].raw), 0);
    end

    // Random weights/activations with bubbles and a 10-cycle output stall.
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < IN; i++) begin
        wm[i] = int'($urandom_range(0, 255)) - 128;
        xv[i] = int'($urandom_range(0, 255)) - 128;
      end
      load_all();
      send_beats(0, BEATS-1, 1'b1, -1);
      finish_vector($sformatf("rand%0d", v), model(), 10);
      for (int i = 0; i < IN; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
      send_beats(0, BEATS-1, 1'b0, -1);
      finish_vector($sformatf("rand%0d_next", v), model(), 0);
    end

    // Weight write attempted at beat 5 must be ignored.
    for (int i = 0; i < IN; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
    send_beats(0, BEATS-1, 1'b0, 5);
    finish_vector("wr_mid_vector", model(), 0);
    send_beats(0, BEATS-1, 1'b1, -1);
    finish_vector("wr_mid_after", model(), 0);

    // Reset partway through a vector discards the partial sum but keeps weights.
    begin
      bit quiet = 1'b1;
      send_beats(0, 8, 1'b0, -1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      for (int c = 0; c < 6; c++) begin
        tick();
        if (out_valid !== 1'b0) quiet = 1'b0;
      end
      check("midrst_quiet", quiet, 1);
      for (int i = 0; i < IN; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
      send_beats(0, BEATS-1, 1'b0, -1);
      finish_vector("midrst_next", model(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
